treino_ctrl: RTL and testbench

- Epoch-loop controller sitting directly around the perceptron epoch stage (epoca). It consumes what epoca produces: per-sample outputs and updated weights.
- It decides convergence and feeds the updated weights back for the next epoch until the outputs match the targets or an epoch limit is reached.
- All data is IEEE-754 half precision (16-bit, 1.0 = 16'h3C00).

---
 rtl/treino_pkg.sv | 21 ++
 rtl/fp16_igual.sv | 20 ++
 rtl/treino_ctrl.sv | 147 ++++++++++++++
 tb/tb_treino_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/treino_pkg.sv
// Shared types and constants for the perceptron epoch-loop controller.
// Sizes, fp16 constants and the controller state encoding live here.
package treino_pkg;

  localparam int TAM_DEF        = 16;
  localparam int N_AMOSTRAS_DEF = 4;

  localparam logic [15:0] FP16_ZERO  = 16'h0000;
  localparam logic [15:0] FP16_NZERO = 16'h8000;
  localparam logic [15:0] FP16_ONE   = 16'h3C00;
  localparam logic [15:0] FP16_HALF  = 16'h3800;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/fp16_igual.sv
// Combinational fp16 equality: bit-identical or both zero (any sign) match.
// A NaN on either side never matches, not even an identical NaN.
module fp16_igual
  import treino_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        igual_o
);

  logic a_nan, b_nan, a_zero, b_zero;

  assign a_nan  = (a_i[14:10] == 5'h1F) && (a_i[9:0] != 10'h000);
  assign b_nan  = (b_i[14:10] == 5'h1F) && (b_i[9:0] != 10'h000);
  assign a_zero = (a_i == FP16_ZERO) || (a_i == FP16_NZERO);
  assign b_zero = (b_i == FP16_ZERO) || (b_i == FP16_NZERO);

  assign igual_o = !a_nan && !b_nan && ((a_i == b_i) || (a_zero && b_zero));

endmodule

// File: rtl/treino_ctrl.sv
// Epoch-loop controller around the perceptron epoch stage: launches epochs,
// feeds back updated weights and stops on convergence or the epoch limit.
module treino_ctrl
  import treino_pkg::*;
#(
  parameter int          TAM        = TAM_DEF,
  parameter int          N_AMOSTRAS = N_AMOSTRAS_DEF,
  parameter int          MAX_EPOCAS = 32,
  parameter logic [15:0] W_INIT     = FP16_ONE,
  localparam int         EPW        = $clog2(MAX_EPOCAS + 1),
  localparam int         ERW        = $clog2(N_AMOSTRAS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N_AMOSTRAS-1:0][TAM-1:0]  d,
  output logic                            ep_start,
  output logic [TAM-1:0]                  ep_w0,
  output logic [TAM-1:0]                  ep_w1,
  output logic [TAM-1:0]                  ep_w2,
  input  logic                            ep_done,
  input  logic [N_AMOSTRAS-1:0][TAM-1:0]  ep_result,
  input  logic [TAM-1:0]                  ep_w0_new,
  input  logic [TAM-1:0]                  ep_w1_new,
  input  logic [TAM-1:0]                  ep_w2_new,
  output logic [TAM-1:0]                  w0,
  output logic [TAM-1:0]                  w1,
  output logic [TAM-1:0]                  w2,
  output logic [EPW-1:0]                  epocas,
  output logic [ERW-1:0]                  erros,
  output logic                            busy,
  output logic                            done,
  output logic                            convergiu
);

  localparam logic [EPW-1:0] MAX_EP = EPW'(MAX_EPOCAS);
  localparam logic [TAM-1:0] W0     = TAM'(W_INIT);

  state_e                          state_q, state_d;
  logic [TAM-1:0]                  w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [EPW-1:0]                  epocas_q, epocas_d;
  logic [ERW-1:0]                  erros_q, erros_d, n_erros;
  logic [N_AMOSTRAS-1:0][TAM-1:0]  res_q, res_d;
  logic                            conv_q, conv_d;
  logic [N_AMOSTRAS-1:0]           igual;

  for (genvar i = 0; i < N_AMOSTRAS; i++) begin : g_cmp
    fp16_igual u_cmp (
      .a_i     (res_q[i]),
      .b_i     (d[i]),
      .igual_o (igual[i])
    );
  end

  always_comb begin
    n_erros = '0;
    for (int i = 0; i < N_AMOSTRAS; i++) begin
      if (!igual[i]) n_erros = n_erros + ERW'(1);
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    epocas_d = epocas_q;
    erros_d  = erros_q;
    res_d    = res_q;
    conv_d   = conv_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = ISSUE;
          w0_d     = W0;
          w1_d     = W0;
          w2_d     = W0;
          epocas_d = '0;
          erros_d  = '0;
          conv_d   = 1'b0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ep_done) begin
          res_d   = ep_result;
          w0_d    = ep_w0_new;
          w1_d    = ep_w1_new;
          w2_d    = ep_w2_new;
          if (epocas_q < MAX_EP) epocas_d = epocas_q + EPW'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        erros_d = n_erros;
        if (n_erros == '0) begin
          state_d = DONE;
          conv_d  = 1'b1;
        end else if (epocas_q == MAX_EP) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      w0_q     <= W0;
      w1_q     <= W0;
      w2_q     <= W0;
      epocas_q <= '0;
      erros_q  <= '0;
      // NOTE: the result register is small and feeds the comparators, so it is reset to keep erros well defined.
      res_q    <= '0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      epocas_q <= epocas_d;
      erros_q  <= erros_d;
      res_q    <= res_d;
      conv_q   <= conv_d;
    end
  end

  assign ep_start  = (state_q == ISSUE);
  assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign convergiu = conv_q;
  assign ep_w0     = w0_q;
  assign ep_w1     = w1_q;
  assign ep_w2     = w2_q;
  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign epocas    = epocas_q;
  assign erros     = erros_q;

endmodule

// File: tb/tb_treino_ctrl.sv
// Directed bench for treino_ctrl with a behavioural epoch stage answering
// three cycles after each ep_start; target d is the OR gate {0,1,1,1}.
module tb_treino_ctrl;
  import treino_pkg::*;

  localparam int MAXE = 4;
  localparam int NA   = N_AMOSTRAS_DEF;
  localparam int EPW  = $clog2(MAXE + 1);
  localparam int ERW  = $clog2(NA + 1);

  typedef logic [NA-1:0][15:0] vec_t;

  logic           clk, reset, start;
  vec_t           d, ep_result;
  logic           ep_start, ep_done, busy, done, convergiu;
  logic [15:0]    ep_w0, ep_w1, ep_w2, ep_w0_new, ep_w1_new, ep_w2_new;
  logic [15:0]    w0, w1, w2;
  logic [EPW-1:0] epocas;
  logic [ERW-1:0] erros;

  treino_ctrl #(
    .TAM        (16),
    .N_AMOSTRAS (NA),
    .MAX_EPOCAS (MAXE),
    .W_INIT     (FP16_ONE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .d         (d),
    .ep_start  (ep_start),
    .ep_w0     (ep_w0),
    .ep_w1     (ep_w1),
    .ep_w2     (ep_w2),
    .ep_done   (ep_done),
    .ep_result (ep_result),
    .ep_w0_new (ep_w0_new),
    .ep_w1_new (ep_w1_new),
    .ep_w2_new (ep_w2_new),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .epocas    (epocas),
    .erros     (erros),
    .busy      (busy),
    .done      (done),
    .convergiu (convergiu)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Epoch model configuration (written by the main sequence) and its observations.
  vec_t        mdl_res [8];
  logic [15:0] mdl_w   [8];
  int          mdl_n    = 1;
  int          run_base = 0;
  int          pulses   = 0;
  int          done_cyc = 0;
  logic [15:0] seen_w0  [64];
  logic [15:0] seen_w2  [64];
  logic [ERW-1:0] seen_err [64];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int cnt;
    int k;
    cnt       = 0;
    ep_done   = 1'b0;
    ep_result = '0;
    ep_w0_new = '0;
    ep_w1_new = '0;
    ep_w2_new = '0;
    forever begin
      @(negedge clk);
      ep_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          k = pulses - 1 - run_base;
          if (k >= mdl_n) k = mdl_n - 1;
          if (k < 0) k = 0;
          ep_done   = 1'b1;
          ep_result = mdl_res[k];
          ep_w0_new = mdl_w[k];
          ep_w1_new = mdl_w[k] + 16'd1;
          ep_w2_new = mdl_w[k] + 16'd2;
          done_cyc  = cyc;
        end
      end
      if (ep_start === 1'b1) begin
        if (pulses < 64) begin
          seen_w0[pulses]  = ep_w0;
          seen_w2[pulses]  = ep_w2;
          seen_err[pulses] = erros;
        end
        pulses++;
        cnt = 3;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_start();
    run_base = pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_reached"}, 32'(done), 32'd1);
    check({tag, "_done_latency"}, 32'(cyc), 32'(done_cyc + 2));
  endtask

  function automatic vec_t mk(input logic [15:0] s0, s1, s2, s3);
    vec_t v;
    v[0] = s0; v[1] = s1; v[2] = s2; v[3] = s3;
    return v;
  endfunction

  initial begin
    vec_t d_or;
    d_or  = mk(16'h0000, 16'h3C00, 16'h3C00, 16'h3C00);
    d     = d_or;
    start = 1'b0;
    reset = 1'b1;
    tick(2);
    check("rst_w0", 32'(w0), 32'h3C00);
    check("rst_w1", 32'(w1), 32'h3C00);
    check("rst_w2", 32'(w2), 32'h3C00);
    check("rst_epocas", 32'(epocas), 32'd0);
    check("rst_erros", 32'(erros), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ep_start", 32'(ep_start), 32'd0);
    check("rst_conv", 32'(convergiu), 32'd0);
    reset = 1'b0;
    tick(1);

    // First epoch already correct.
    mdl_n = 1; mdl_res[0] = d_or; mdl_w[0] = 16'h3C00;
    run_start();
    check("a_ep_start", 32'(ep_start), 32'd1);
    check("a_busy", 32'(busy), 32'd1);
    tick(1);
    check("a_ep_start_one_cycle", 32'(ep_start), 32'd0);
    wait_done("a");
    check("a_pulses", 32'(pulses - run_base), 32'd1);
    check("a_conv", 32'(convergiu), 32'd1);
    check("a_epocas", 32'(epocas), 32'd1);
    check("a_erros", 32'(erros), 32'd0);
    check("a_busy_low", 32'(busy), 32'd0);
    check("a_w1", 32'(w1), 32'h3C01);

    // 2, 1, 0 mismatches with shrinking weights; restart from DONE.
    mdl_n = 3;
    mdl_res[0] = mk(16'h3C00, 16'h0000, 16'h3C00, 16'h3C00); mdl_w[0] = 16'h3800;
    mdl_res[1] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00); mdl_w[1] = 16'h3400;
    mdl_res[2] = d_or;                                        mdl_w[2] = 16'h3000;
    run_start();
    wait_done("b");
    check("b_pulses", 32'(pulses - run_base), 32'd3);
    check("b_w0_p0", 32'(seen_w0[run_base]), 32'h3C00);
    check("b_w0_p1", 32'(seen_w0[run_base + 1]), 32'h3800);
    check("b_w0_p2", 32'(seen_w0[run_base + 2]), 32'h3400);
    check("b_w2_p2", 32'(seen_w2[run_base + 2]), 32'h3402);
    check("b_err_p1", 32'(seen_err[run_base + 1]), 32'd2);
    check("b_err_p2", 32'(seen_err[run_base + 2]), 32'd1);
    check("b_w0", 32'(w0), 32'h3000);
    check("b_w2", 32'(w2), 32'h3002);
    check("b_epocas", 32'(epocas), 32'd3);
    check("b_conv", 32'(convergiu), 32'd1);

    // Always wrong on sample 0: hits the epoch limit; start in DONE reloads weights.
    mdl_n = 1; mdl_res[0] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00); mdl_w[0] = 16'h3800;
    run_start();
    check("c_ep_start", 32'(ep_start), 32'd1);
    check("c_reload_w0", 32'(w0), 32'h3C00);
    check("c_reload_w2", 32'(w2), 32'h3C00);
    check("c_clear_epocas", 32'(epocas), 32'd0);
    check("c_clear_conv", 32'(convergiu), 32'd0);
    wait_done("c");
    check("c_pulses", 32'(pulses - run_base), 32'd4);
    check("c_conv", 32'(convergiu), 32'd0);
    check("c_epocas", 32'(epocas), 32'd4);
    check("c_erros", 32'(erros), 32'd1);

    // Negative zero matches positive zero.
    mdl_n = 1; mdl_res[0] = mk(16'h8000, 16'h3C00, 16'h3C00, 16'h3C00); mdl_w[0] = 16'h3800;
    run_start();
    wait_done("d");
    check("d_conv", 32'(convergiu), 32'd1);
    check("d_erros", 32'(erros), 32'd0);
    check("d_epocas", 32'(epocas), 32'd1);

    // NaN never matches.
    mdl_n = 1; mdl_res[0] = mk(16'h0000, 16'h7E00, 16'h3C00, 16'h3C00); mdl_w[0] = 16'h3800;
    run_start();
    wait_done("e");
    check("e_conv", 32'(convergiu), 32'd0);
    check("e_erros", 32'(erros), 32'd1);
    check("e_epocas", 32'(epocas), 32'd4);

    // start pulsed during WAIT is ignored.
    mdl_n = 1; mdl_res[0] = d_or; mdl_w[0] = 16'h3C00;
    run_start();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("f");
    check("f_pulses", 32'(pulses - run_base), 32'd1);
    check("f_epocas", 32'(epocas), 32'd1);
    check("f_conv", 32'(convergiu), 32'd1);

    // Reset in WAIT; the late ep_done must not be captured.
    mdl_n = 1; mdl_res[0] = d_or; mdl_w[0] = 16'h3000;
    run_start();
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    check("g_busy", 32'(busy), 32'd0);
    check("g_done", 32'(done), 32'd0);
    check("g_epocas", 32'(epocas), 32'd0);
    check("g_w0", 32'(w0), 32'h3C00);
    check("g_ep_start", 32'(ep_start), 32'd0);
    check("g_model_answered", 32'(done_cyc > 0 && cyc - done_cyc < 8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
